// File: rtl/add4_acc_ctrl.sv
// rtl/add4_acc_ctrl.sv - beat accumulator that time-shares one registered add4 through a feedback input
// The add4 output register doubles as the running partial sum; the controller only steers its inputs.

module add4 #(
  parameter int WIDTH_IN = 8,
  localparam int DW = WIDTH_IN + 11
) (
  input  logic                 clk,
  input  logic signed [DW-1:0] in  [3:0],
  output logic signed [DW-1:0] out
);

  always_ff @(posedge clk) begin
    out <= in[0] + in[1] + in[2] + in[3];
  end

endmodule

module add4_acc_ctrl #(
  parameter int WIDTH_IN = 8,
  parameter int BEATS    = 4,
  localparam int DW = WIDTH_IN + 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data [2:0],
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 busy
);

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {
    ACC,
    OUT
  } state_t;

  state_t                st;
  logic [CW-1:0]         beat_cnt;
  logic                  accept;
  logic signed [DW-1:0]  add_in [3:0];
  logic signed [DW-1:0]  add_out;

  assign s_ready = (st == ACC) || ((st == OUT) && m_ready);
  assign accept  = s_valid && s_ready;
  assign m_data  = m_valid ? add_out : '0;
  assign busy    = (beat_cnt != '0) || (st == OUT);

  // Without an accepted beat the adder re-adds its own output to zeros, so the sum holds.
  // A first beat forces the feedback to zero so a stale or unreset sum never leaks in.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      add_in[i] = accept ? s_data[i] : '0;
    end
    add_in[3] = (accept && (beat_cnt == '0)) ? '0 : add_out;
  end

  add4 #(
    .WIDTH_IN(WIDTH_IN)
  ) u_add4 (
    .clk(clk),
    .in (add_in),
    .out(add_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ACC;
      beat_cnt <= '0;
      m_valid  <= 1'b0;
    end else begin
      case (st)
        ACC: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              st       <= OUT;
              m_valid  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            if (accept && (BEATS == 1)) begin
              st       <= OUT;
              m_valid  <= 1'b1;
              beat_cnt <= '0;
            end else if (accept) begin
              st       <= ACC;
              m_valid  <= 1'b0;
              beat_cnt <= CW'(1);
            end else begin
              st       <= ACC;
              m_valid  <= 1'b0;
              beat_cnt <= '0;
            end
          end
        end
        default: begin
          st       <= ACC;
          m_valid  <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add4_acc_ctrl.sv
// tb/tb_add4_acc_ctrl.sv - scoreboard bench for add4_acc_ctrl with directed beat vectors

module tb_add4_acc_ctrl;

  localparam int WIDTH_IN = 8;
  localparam int BEATS    = 4;
  localparam int DW       = WIDTH_IN + 11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data [2:0];
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] m_data;
  logic                 busy;

  int tests = 0;
  int fails = 0;
  logic signed [DW-1:0] exp_q [$];
  logic signed [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  add4_acc_ctrl #(
    .WIDTH_IN(WIDTH_IN),
    .BEATS   (BEATS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .busy   (busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Drive phase is 1 time unit after the rising edge; samples are taken on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b, input int c, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    s_valid = 1'b1;
    s_data[0] = DW'(a);
    s_data[1] = DW'(b);
    s_data[2] = DW'(c);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) waits++;
      step();
    end
    if (!ok) check("beat_timeout", 0, 1);
    s_valid = 1'b0;
    s_data[0] = '0;
    s_data[1] = '0;
    s_data[2] = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", longint'(m_data), 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_data", longint'(m_data), longint'(mon_exp));
      end
    end
  end

  initial begin
    int w;
    s_data[0] = '0;
    s_data[1] = '0;
    s_data[2] = '0;

    repeat (3) step();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", longint'(m_data), 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // 1: back-to-back, consumer always ready
    m_ready = 1'b1;
    exp_q.push_back(DW'(78));
    beat(1, 2, 3, w);    check("s1_ready_b1", w, 0);
    beat(4, 5, 6, w);    check("s1_ready_b2", w, 0);
    beat(7, 8, 9, w);    check("s1_ready_b3", w, 0);
    beat(10, 11, 12, w); check("s1_ready_b4", w, 0);
    @(negedge clk);
    check("s1_valid", m_valid, 1);
    check("s1_s_ready_out", s_ready, 1);
    step();
    @(negedge clk);
    check("s1_valid_pulse", m_valid, 0);
    check("s1_busy_idle", busy, 0);
    step();

    // 2: two-cycle bubble between beats 2 and 3
    exp_q.push_back(DW'(78));
    beat(1, 2, 3, w);
    beat(4, 5, 6, w);
    repeat (2) begin
      @(negedge clk);
      check("s2_bubble_busy", busy, 1);
      check("s2_bubble_valid", m_valid, 0);
      step();
    end
    beat(7, 8, 9, w);
    beat(10, 11, 12, w);
    @(negedge clk);
    check("s2_valid", m_valid, 1);
    step();

    // 3: negative operands
    exp_q.push_back(DW'(-60));
    repeat (4) beat(-5, -5, -5, w);
    @(negedge clk);
    check("s3_valid", m_valid, 1);
    step();

    // 4: backpressure, then handshake and first beat in the same cycle
    m_ready = 1'b0;
    exp_q.push_back(DW'(24));
    repeat (4) beat(2, 2, 2, w);
    repeat (3) begin
      @(negedge clk);
      check("s4_hold_valid", m_valid, 1);
      check("s4_hold_data", longint'(m_data), 24);
      check("s4_hold_s_ready", s_ready, 0);
      check("s4_hold_busy", busy, 1);
      step();
    end
    m_ready = 1'b1;
    exp_q.push_back(DW'(12));
    beat(1, 1, 1, w);
    check("s4_same_cycle_accept", w, 0);
    @(negedge clk);
    check("s4_after_valid", m_valid, 0);
    check("s4_after_busy", busy, 1);
    step();
    repeat (3) beat(1, 1, 1, w);
    @(negedge clk);
    check("s4_valid", m_valid, 1);
    step();

    // 5: wrap modulo 2^19
    exp_q.push_back(DW'(-12));
    repeat (4) beat(131071, 131071, 131071, w);
    @(negedge clk);
    check("s5_valid", m_valid, 1);
    step();

    // 6: asynchronous reset mid-accumulation
    beat(1, 2, 3, w);
    beat(4, 5, 6, w);
    rst = 1'b1;
    #1;
    check("s6_rst_m_valid", m_valid, 0);
    check("s6_rst_s_ready", s_ready, 1);
    check("s6_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    exp_q.push_back(DW'(12));
    repeat (4) beat(1, 1, 1, w);
    @(negedge clk);
    check("s6_valid", m_valid, 1);
    step();

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
